// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: FSM state encoding and default
// frequency constants used by the control, counter and display blocks.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } sw_state_t;

  localparam int unsigned DEF_CLK_HZ       = 100_000_000;
  localparam int unsigned DEF_TICK_HZ      = 1;
  localparam int unsigned DEF_FAST_MULT    = 4;
  localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;

  // The prescaler advances only while the stopwatch is counting.
  function automatic logic is_counting(input sw_state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, consecutive-sample debounce
// counter and rising-edge event generator for one raw button.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, debounce state and registered edge marker.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: conditions the three buttons, runs the
// IDLE/RUN/PAUSE/LAP FSM and generates tick, clr and hold for the counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
  parameter int unsigned TICK_HZ      = DEF_TICK_HZ,
  parameter int unsigned FAST_MULT    = DEF_FAST_MULT,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clr,
  input  logic       speed_up,
  output logic       tick,
  output logic       clr,
  output logic       hold,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned PRESC_FULL = CLK_HZ / TICK_HZ;
  localparam int unsigned PRESC_W    = $clog2(PRESC_FULL);
  localparam logic [PRESC_W-1:0] TERM_NORM = PRESC_W'(PRESC_FULL - 1);
  localparam logic [PRESC_W-1:0] TERM_FAST = PRESC_W'(CLK_HZ / (TICK_HZ * FAST_MULT) - 1);

  logic lvl_start, lvl_lap, lvl_clr;
  logic rise_start, rise_lap, rise_clr;
  logic ev_start, ev_lap, ev_clr;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_start (
    .clk(clk), .reset(reset), .btn_raw(btn_start), .level(lvl_start), .rise(rise_start)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_lap (
    .clk(clk), .reset(reset), .btn_raw(btn_lap), .level(lvl_lap), .rise(rise_lap)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clr (
    .clk(clk), .reset(reset), .btn_raw(btn_clr), .level(lvl_clr), .rise(rise_clr)
  );

  // The edge marker and the accepted level go high on the same edge.
  assign ev_start = rise_start & lvl_start;
  assign ev_lap   = rise_lap   & lvl_lap;
  assign ev_clr   = rise_clr   & lvl_clr;

  sw_state_t          state_q, state_d;
  logic               hold_q, hold_d;
  logic               clr_q, clr_d;
  logic               tick_q, tick_d;
  logic               running_q;
  logic               presc_zero;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] term;
  logic [1:0]         spd_sync_q;

  // FSM next state; priority start > clr > lap, losing events are dropped.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    clr_d      = 1'b0;
    presc_zero = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ev_start) begin
          state_d    = ST_RUN;
          presc_zero = 1'b1;
        end else if (ev_clr) begin
          clr_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (ev_start) begin
          state_d = ST_PAUSE;
        end else if (!ev_clr && ev_lap) begin
          state_d = ST_LAP;
          hold_d  = 1'b1;
        end
      end
      ST_LAP: begin
        if (ev_start) begin
          state_d = ST_PAUSE;
          hold_d  = 1'b0;
        end else if (!ev_clr && ev_lap) begin
          state_d = ST_RUN;
          hold_d  = 1'b0;
        end
      end
      ST_PAUSE: begin
        if (ev_start) begin
          state_d = ST_RUN;
        end else if (ev_clr) begin
          state_d    = ST_IDLE;
          clr_d      = 1'b1;
          presc_zero = 1'b1;
        end
      end
    endcase
  end

  // Prescaler: >= compare so a late switch to fast mode ticks at once.
  assign term = spd_sync_q[1] ? TERM_FAST : TERM_NORM;

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (presc_zero) begin
      presc_d = '0;
    end else if (is_counting(state_q)) begin
      if (presc_q >= term) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Registered FSM, prescaler, speed synchroniser and outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= 1'b0;
      clr_q      <= 1'b0;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      presc_q    <= '0;
      spd_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      clr_q      <= clr_d;
      tick_q     <= tick_d;
      running_q  <= is_counting(state_d);
      presc_q    <= presc_d;
      spd_sync_q <= {spd_sync_q[0], speed_up};
    end
  end

  assign tick    = tick_q;
  assign clr     = clr_q;
  assign hold    = hold_q;
  assign running = running_q;
  assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_HZ=40, TICK_HZ=1, FAST_MULT=4,
// DEBOUNCE_CYC=4. Button press to state change is 2+4+1 = 7 edges.
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clr = 1'b0;
  logic       speed_up = 1'b0;
  logic       tick, clr, hold, running;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  stopwatch_ctrl #(
    .CLK_HZ(40), .TICK_HZ(1), .FAST_MULT(4), .DEBOUNCE_CYC(4)
  ) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap),
    .btn_clr(btn_clr), .speed_up(speed_up), .tick(tick), .clr(clr),
    .hold(hold), .running(running), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance n rising edges; inputs are driven and outputs sampled 1 unit later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Steps until tick is seen (or max edges pass); returns edges taken.
  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (tick !== 1'b1 && n < max);
  endtask

  task automatic test_reset;
    reset = 1'b0; btn_start = 1'b1; btn_lap = 1'b1; btn_clr = 1'b1;
    step(3);
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL rst_tick: got %b want 0", tick); end
    n_cmp++; if (clr !== 1'b0) begin n_bad++; $display("FAIL rst_clr: got %b want 0", clr); end
    n_cmp++; if (hold !== 1'b0) begin n_bad++; $display("FAIL rst_hold: got %b want 0", hold); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL rst_running: got %b want 0", running); end
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL rst_state: got %b want %b", state, S_IDLE); end
    reset = 1'b1;
    step(6);
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL rst_rel_early: got %b want %b", state, S_IDLE); end
    step(1);
    n_cmp++; if (state !== S_RUN) begin n_bad++; $display("FAIL rst_rel_start: got %b want %b", state, S_RUN); end
    n_cmp++; if (clr !== 1'b0) begin n_bad++; $display("FAIL rst_rel_noclr: got %b want 0", clr); end
    reset = 1'b0; btn_start = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL rst_again: got %b want %b", state, S_IDLE); end
  endtask

  task automatic test_start_rates;
    int n;
    btn_start = 1'b1;
    step(6);
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL start_early: got %b want %b", state, S_IDLE); end
    step(1);
    n_cmp++; if (state !== S_RUN) begin n_bad++; $display("FAIL start_state: got %b want %b", state, S_RUN); end
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL start_running: got %b want 1", running); end
    btn_start = 1'b0;
    wait_tick(60, n);
    n_cmp++; if (n != 40) begin n_bad++; $display("FAIL first_tick: got %0d cycles want 40", n); end
    step(1);
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL tick_width: got %b want 0", tick); end
    wait_tick(60, n);
    n_cmp++; if (n != 39) begin n_bad++; $display("FAIL tick_period_norm: got %0d cycles want 39", n); end
    step(25);
    speed_up = 1'b1;
    wait_tick(60, n);
    n_cmp++; if (n != 3) begin n_bad++; $display("FAIL fast_past_term: got %0d cycles want 3", n); end
    wait_tick(60, n);
    n_cmp++; if (n != 10) begin n_bad++; $display("FAIL tick_period_fast1: got %0d cycles want 10", n); end
    wait_tick(60, n);
    n_cmp++; if (n != 10) begin n_bad++; $display("FAIL tick_period_fast2: got %0d cycles want 10", n); end
    speed_up = 1'b0;
    wait_tick(60, n);
    n_cmp++; if (n != 40) begin n_bad++; $display("FAIL tick_period_back: got %0d cycles want 40", n); end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 4; i++) begin
      btn_start = 1'b1; step(3);
      btn_start = 1'b0; step(1);
    end
    step(8);
    n_cmp++; if (state !== S_RUN) begin n_bad++; $display("FAIL bounce_reject: got %b want %b", state, S_RUN); end
    btn_start = 1'b1;
    step(7);
    n_cmp++; if (state !== S_PAUSE) begin n_bad++; $display("FAIL stable_press: got %b want %b", state, S_PAUSE); end
    btn_start = 1'b0;
    step(12);
    n_cmp++; if (state !== S_PAUSE) begin n_bad++; $display("FAIL single_event: got %b want %b", state, S_PAUSE); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL pause_running: got %b want 0", running); end
    btn_start = 1'b1;
    step(7);
    n_cmp++; if (state !== S_RUN) begin n_bad++; $display("FAIL bounce_resume: got %b want %b", state, S_RUN); end
    btn_start = 1'b0;
    step(9);
  endtask

  task automatic test_lap;
    int n;
    wait_tick(60, n);
    btn_lap = 1'b1;
    step(7);
    n_cmp++; if (state !== S_LAP) begin n_bad++; $display("FAIL lap_state: got %b want %b", state, S_LAP); end
    n_cmp++; if (hold !== 1'b1) begin n_bad++; $display("FAIL lap_hold: got %b want 1", hold); end
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL lap_running: got %b want 1", running); end
    btn_lap = 1'b0;
    wait_tick(60, n);
    n_cmp++; if (n != 33) begin n_bad++; $display("FAIL lap_tick_phase: got %0d cycles want 33", n); end
    wait_tick(60, n);
    n_cmp++; if (n != 40) begin n_bad++; $display("FAIL lap_tick_period: got %0d cycles want 40", n); end
    btn_lap = 1'b1;
    step(7);
    n_cmp++; if (state !== S_RUN) begin n_bad++; $display("FAIL lap_return: got %b want %b", state, S_RUN); end
    n_cmp++; if (hold !== 1'b0) begin n_bad++; $display("FAIL lap_unhold: got %b want 0", hold); end
    btn_lap = 1'b0;
    step(9);
    btn_lap = 1'b1;
    step(7);
    n_cmp++; if (state !== S_LAP) begin n_bad++; $display("FAIL lap_again: got %b want %b", state, S_LAP); end
    btn_lap = 1'b0;
    step(9);
    btn_start = 1'b1;
    step(7);
    n_cmp++; if (state !== S_PAUSE) begin n_bad++; $display("FAIL lap_to_pause: got %b want %b", state, S_PAUSE); end
    n_cmp++; if (hold !== 1'b0) begin n_bad++; $display("FAIL lap_pause_hold: got %b want 0", hold); end
    btn_start = 1'b0;
    step(9);
  endtask

  task automatic test_pause_clear;
    int n;
    int ticks;
    logic clr_seen;
    btn_start = 1'b1;
    step(7);
    n_cmp++; if (state !== S_RUN) begin n_bad++; $display("FAIL pc_resume0: got %b want %b", state, S_RUN); end
    btn_start = 1'b0;
    wait_tick(60, n);
    step(10);
    btn_start = 1'b1;
    step(7);
    n_cmp++; if (state !== S_PAUSE) begin n_bad++; $display("FAIL pause_at17: got %b want %b", state, S_PAUSE); end
    btn_start = 1'b0;
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (tick === 1'b1) ticks++;
    end
    n_cmp++; if (ticks != 0) begin n_bad++; $display("FAIL pause_no_tick: got %0d ticks want 0", ticks); end
    btn_start = 1'b1;
    step(7);
    n_cmp++; if (state !== S_RUN) begin n_bad++; $display("FAIL pc_resume: got %b want %b", state, S_RUN); end
    btn_start = 1'b0;
    wait_tick(60, n);
    n_cmp++; if (n != 23) begin n_bad++; $display("FAIL resume_partial: got %0d cycles want 23", n); end
    btn_clr = 1'b1;
    clr_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (clr === 1'b1) clr_seen = 1'b1;
    end
    n_cmp++; if (clr_seen !== 1'b0) begin n_bad++; $display("FAIL clr_in_run_pulse: got %b want 0", clr_seen); end
    n_cmp++; if (state !== S_RUN) begin n_bad++; $display("FAIL clr_in_run_state: got %b want %b", state, S_RUN); end
    btn_clr = 1'b0;
    step(9);
    btn_start = 1'b1;
    step(7);
    n_cmp++; if (state !== S_PAUSE) begin n_bad++; $display("FAIL pc_pause: got %b want %b", state, S_PAUSE); end
    btn_start = 1'b0;
    step(9);
    btn_clr = 1'b1;
    step(6);
    n_cmp++; if (clr !== 1'b0) begin n_bad++; $display("FAIL clr_early: got %b want 0", clr); end
    step(1);
    n_cmp++; if (clr !== 1'b1) begin n_bad++; $display("FAIL clr_pulse: got %b want 1", clr); end
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL clr_to_idle: got %b want %b", state, S_IDLE); end
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL clr_tick_excl: got %b want 0", tick); end
    step(1);
    n_cmp++; if (clr !== 1'b0) begin n_bad++; $display("FAIL clr_one_cycle: got %b want 0", clr); end
    btn_clr = 1'b0;
    step(9);
    btn_clr = 1'b1;
    step(7);
    n_cmp++; if (clr !== 1'b1) begin n_bad++; $display("FAIL clr_idle_pulse: got %b want 1", clr); end
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL clr_idle_state: got %b want %b", state, S_IDLE); end
    btn_clr = 1'b0;
    step(9);
  endtask

  task automatic test_simultaneous;
    logic clr_seen;
    btn_start = 1'b1;
    step(7);
    n_cmp++; if (state !== S_RUN) begin n_bad++; $display("FAIL sim_run: got %b want %b", state, S_RUN); end
    btn_start = 1'b0;
    step(9);
    btn_start = 1'b1;
    step(7);
    n_cmp++; if (state !== S_PAUSE) begin n_bad++; $display("FAIL sim_pause: got %b want %b", state, S_PAUSE); end
    btn_start = 1'b0;
    step(9);
    btn_start = 1'b1;
    btn_clr = 1'b1;
    clr_seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (clr === 1'b1) clr_seen = 1'b1;
    end
    n_cmp++; if (state !== S_RUN) begin n_bad++; $display("FAIL sim_start_wins: got %b want %b", state, S_RUN); end
    btn_start = 1'b0;
    btn_clr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(1);
      if (clr === 1'b1) clr_seen = 1'b1;
    end
    n_cmp++; if (clr_seen !== 1'b0) begin n_bad++; $display("FAIL sim_no_clr: got %b want 0", clr_seen); end
    n_cmp++; if (state !== S_RUN) begin n_bad++; $display("FAIL sim_not_queued: got %b want %b", state, S_RUN); end
  endtask

  task automatic test_reset_mid_run;
    int n;
    wait_tick(60, n);
    step(39);
    reset = 1'b0;
    step(1);
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL midrst_tick: got %b want 0", tick); end
    n_cmp++; if (state !== S_IDLE) begin n_bad++; $display("FAIL midrst_state: got %b want %b", state, S_IDLE); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL midrst_running: got %b want 0", running); end
    n_cmp++; if (hold !== 1'b0 || clr !== 1'b0) begin n_bad++; $display("FAIL midrst_hold_clr: got %b%b want 00", hold, clr); end
    reset = 1'b1;
    step(3);
    n_cmp++; if (state !== S_IDLE || tick !== 1'b0) begin n_bad++; $display("FAIL midrst_after: got state %b tick %b want 00 0", state, tick); end
  endtask

  initial begin
    test_reset();
    test_start_rates();
    test_bounce();
    test_lap();
    test_pause_clear();
    test_simultaneous();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
